// File: rtl/mem_channel_arbiter.sv
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS LSUs, one request FSM per channel.
// Define MEMARB_ROUND_ROBIN_EN for a per-channel round-robin scan; otherwise fixed lowest-index priority.
module mem_channel_arbiter #(
   parameter int unsigned ADDR_BITS     = 8,
   parameter int unsigned DATA_BITS     = 8,
   parameter int unsigned NUM_CONSUMERS = 8,
   parameter int unsigned NUM_CHANNELS  = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]            mem_read_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
   output logic [NUM_CHANNELS-1:0]            mem_write_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
   output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
   input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

   localparam int unsigned CW = $clog2(NUM_CONSUMERS);

   typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

   state_t                           state_q [NUM_CHANNELS];
   state_t                           state_n [NUM_CHANNELS];
   logic [CW-1:0]                    owner_q [NUM_CHANNELS];
   logic [CW-1:0]                    owner_n [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]          is_wr_q, is_wr_n;
   logic [NUM_CONSUMERS-1:0]         claimed_q, claimed_n;
   logic [NUM_CONSUMERS-1:0]         crr_n, cwr_n;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] crd_n;
   logic [NUM_CHANNELS-1:0]          mrv_n, mwv_n;
   logic [NUM_CHANNELS*ADDR_BITS-1:0] mra_n, mwa_n;
   logic [NUM_CHANNELS*DATA_BITS-1:0] mwd_n;
`ifdef MEMARB_ROUND_ROBIN_EN
   logic [CW-1:0]                    rr_q [NUM_CHANNELS];
   logic [CW-1:0]                    rr_n [NUM_CHANNELS];
`endif

   // Next-state for all channels; lower channels claim first through the taken chain
   always_comb begin
      logic [NUM_CONSUMERS-1:0] taken;
      logic found;
      int   sel;
      int   idx;
      int   o;
      state_n   = state_q;
      owner_n   = owner_q;
      is_wr_n   = is_wr_q;
      claimed_n = claimed_q;
      crr_n     = consumer_read_ready;
      crd_n     = consumer_read_data;
      cwr_n     = consumer_write_ready;
      mrv_n     = mem_read_valid;
      mra_n     = mem_read_address;
      mwv_n     = mem_write_valid;
      mwa_n     = mem_write_address;
      mwd_n     = mem_write_data;
`ifdef MEMARB_ROUND_ROBIN_EN
      rr_n      = rr_q;
`endif
      taken     = claimed_q;
      found     = 1'b0;
      sel       = 0;
      idx       = 0;
      o         = 0;
      for (int ch = 0; ch < int'(NUM_CHANNELS); ch++) begin
         o = int'(owner_q[ch]);
         case (state_q[ch])
            IDLE: begin
               found = 1'b0;
               sel   = 0;
               for (int i = 0; i < int'(NUM_CONSUMERS); i++) begin
`ifdef MEMARB_ROUND_ROBIN_EN
                  idx = int'(rr_q[ch]) + i;
                  if (idx >= int'(NUM_CONSUMERS)) idx = idx - int'(NUM_CONSUMERS);
`else
                  idx = i;
`endif
                  if (!found && !taken[idx] &&
                      (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
                     found = 1'b1;
                     sel   = idx;
                  end
               end
               if (found) begin
                  taken[sel]     = 1'b1;
                  claimed_n[sel] = 1'b1;
                  owner_n[ch]    = CW'(sel);
`ifdef MEMARB_ROUND_ROBIN_EN
                  rr_n[ch] = (sel == int'(NUM_CONSUMERS) - 1) ? '0 : CW'(sel + 1);
`endif
                  // Read wins when both valids are up; the write stays pending
                  if (consumer_read_valid[sel]) begin
                     is_wr_n[ch] = 1'b0;
                     mrv_n[ch]   = 1'b1;
                     mra_n[ch*ADDR_BITS +: ADDR_BITS] = consumer_read_address[sel*ADDR_BITS +: ADDR_BITS];
                     state_n[ch] = READ_WAIT;
                  end else begin
                     is_wr_n[ch] = 1'b1;
                     mwv_n[ch]   = 1'b1;
                     mwa_n[ch*ADDR_BITS +: ADDR_BITS] = consumer_write_address[sel*ADDR_BITS +: ADDR_BITS];
                     mwd_n[ch*DATA_BITS +: DATA_BITS] = consumer_write_data[sel*DATA_BITS +: DATA_BITS];
                     state_n[ch] = WRITE_WAIT;
                  end
               end
            end
            READ_WAIT: begin
               if (mem_read_ready[ch]) begin
                  crd_n[o*DATA_BITS +: DATA_BITS] = mem_read_data[ch*DATA_BITS +: DATA_BITS];
                  crr_n[o]    = 1'b1;
                  mrv_n[ch]   = 1'b0;
                  state_n[ch] = RELAY;
               end
            end
            WRITE_WAIT: begin
               if (mem_write_ready[ch]) begin
                  cwr_n[o]    = 1'b1;
                  mwv_n[ch]   = 1'b0;
                  state_n[ch] = RELAY;
               end
            end
            RELAY: begin
               if (is_wr_q[ch] ? !consumer_write_valid[o] : !consumer_read_valid[o]) begin
                  if (is_wr_q[ch]) cwr_n[o] = 1'b0;
                  else             crr_n[o] = 1'b0;
                  claimed_n[o] = 1'b0;
                  state_n[ch]  = IDLE;
               end
            end
            default: state_n[ch] = IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int ch = 0; ch < int'(NUM_CHANNELS); ch++) begin
            state_q[ch] <= IDLE;
            owner_q[ch] <= '0;
`ifdef MEMARB_ROUND_ROBIN_EN
            rr_q[ch]    <= '0;
`endif
         end
         is_wr_q              <= '0;
         claimed_q            <= '0;
         consumer_read_ready  <= '0;
         consumer_read_data   <= '0;
         consumer_write_ready <= '0;
         mem_read_valid       <= '0;
         mem_read_address     <= '0;
         mem_write_valid      <= '0;
         mem_write_address    <= '0;
         mem_write_data       <= '0;
      end else begin
         state_q              <= state_n;
         owner_q              <= owner_n;
`ifdef MEMARB_ROUND_ROBIN_EN
         rr_q                 <= rr_n;
`endif
         is_wr_q              <= is_wr_n;
         claimed_q            <= claimed_n;
         consumer_read_ready  <= crr_n;
         consumer_read_data   <= crd_n;
         consumer_write_ready <= cwr_n;
         mem_read_valid       <= mrv_n;
         mem_read_address     <= mra_n;
         mem_write_valid      <= mwv_n;
         mem_write_address    <= mwa_n;
         mem_write_data       <= mwd_n;
      end
   end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench for mem_channel_arbiter: a 4-channel instance for transactions and
// a 1-channel instance for grant-order fairness.
module tb_mem_channel_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  crv, cwv, crr, cwr;
   logic [63:0] cra, cwa, cwd, crd;
   logic [3:0]  mrv, mrr, mwv, mwr;
   logic [31:0] mra, mrd, mwa, mwd;

   logic [7:0]  f_crv, f_cwv, f_crr, f_cwr;
   logic [63:0] f_cra, f_cwa, f_cwd, f_crd;
   logic [0:0]  f_mrv, f_mrr, f_mwv, f_mwr;
   logic [7:0]  f_mra, f_mrd, f_mwa, f_mwd;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(4)) dut (
      .clk(clk), .reset(reset),
      .consumer_read_valid(crv), .consumer_read_address(cra),
      .consumer_read_ready(crr), .consumer_read_data(crd),
      .consumer_write_valid(cwv), .consumer_write_address(cwa),
      .consumer_write_data(cwd), .consumer_write_ready(cwr),
      .mem_read_valid(mrv), .mem_read_address(mra),
      .mem_read_ready(mrr), .mem_read_data(mrd),
      .mem_write_valid(mwv), .mem_write_address(mwa),
      .mem_write_data(mwd), .mem_write_ready(mwr)
   );

   mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(1)) dut_one (
      .clk(clk), .reset(reset),
      .consumer_read_valid(f_crv), .consumer_read_address(f_cra),
      .consumer_read_ready(f_crr), .consumer_read_data(f_crd),
      .consumer_write_valid(f_cwv), .consumer_write_address(f_cwa),
      .consumer_write_data(f_cwd), .consumer_write_ready(f_cwr),
      .mem_read_valid(f_mrv), .mem_read_address(f_mra),
      .mem_read_ready(f_mrr), .mem_read_data(f_mrd),
      .mem_write_valid(f_mwv), .mem_write_address(f_mwa),
      .mem_write_data(f_mwd), .mem_write_ready(f_mwr)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int order [9];
      int n;
      int expg;
      logic prev;

      crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0; mrr = '0; mrd = '0; mwr = '0;
      f_crv = '0; f_cwv = '0; f_cra = '0; f_cwa = '0; f_cwd = '0;
      f_mrr = '0; f_mrd = '0; f_mwr = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_mrv", 64'(mrv), 64'h0);
      chk("rst_mwv", 64'(mwv), 64'h0);
      chk("rst_crr", 64'(crr), 64'h0);
      chk("rst_crd", crd, 64'h0);

      // Fairness on a single channel: consumers re-request as soon as ready drops
      for (int i = 0; i < 8; i++) f_cra[i*8 +: 8] = 8'(i);
      f_mrr = 1'b1;
      f_crv = 8'hFF;
      n = 0;
      prev = 1'b0;
      for (int cyc = 0; cyc < 60 && n < 9; cyc++) begin
         tick();
         if (f_mrv[0] && !prev) begin
            order[n] = int'(f_mra);
            n++;
         end
         prev  = f_mrv[0];
         f_crv = ~f_crr;
      end
      chk("fair_count", 64'(n), 64'd9);
      for (int k = 0; k < n; k++) begin
`ifdef MEMARB_ROUND_ROBIN_EN
         expg = k % 8;
`else
         expg = 0;
`endif
         chk($sformatf("fair_grant%0d", k), 64'(order[k]), 64'(expg));
      end
      f_crv = '0;
      f_mrr = '0;

      // Single read: consumer 3, address 0x05, data 0x2A
      cra[24 +: 8] = 8'h05;
      crv[3] = 1'b1;
      tick();
      chk("t1_mrv", 64'(mrv), 64'h1);
      chk("t1_mra", 64'(mra[7:0]), 64'h05);
      cra[24 +: 8] = 8'h77;
      tick();
      chk("t1_mrv_hold", 64'(mrv), 64'h1);
      chk("t1_mra_ignored", 64'(mra[7:0]), 64'h05);
      mrr[0] = 1'b1;
      mrd[7:0] = 8'h2A;
      tick();
      chk("t1_crr", 64'(crr), 64'h08);
      chk("t1_crd", 64'(crd[31:24]), 64'h2A);
      chk("t1_mrv_low", 64'(mrv), 64'h0);
      mrr = '0;
      tick();
      chk("t1_crr_hold", 64'(crr), 64'h08);
      chk("t1_crd_hold", 64'(crd[31:24]), 64'h2A);
      crv[3] = 1'b0;
      tick();
      chk("t1_crr_drop", 64'(crr), 64'h0);

      // Five simultaneous reads on four channels
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) cra[i*8 +: 8] = 8'(16 + i);
      crv = 8'h1F;
      tick();
      chk("t2_mrv", 64'(mrv), 64'hF);
      chk("t2_mra", 64'(mra), 64'h13121110);
      mrr = 4'b0100;
      mrd[23:16] = 8'h99;
      tick();
      chk("t2_crr", 64'(crr), 64'h04);
      chk("t2_crd", 64'(crd[23:16]), 64'h99);
      chk("t2_mrv_ch2_low", 64'(mrv), 64'hB);
      mrr = '0;
      crv[2] = 1'b0;
      tick();
      chk("t2_crr_drop", 64'(crr), 64'h0);
      chk("t2_ch2_idle", 64'(mrv), 64'hB);
      tick();
      chk("t2_mrv_refill", 64'(mrv), 64'hF);
      chk("t2_mra_c4", 64'(mra[23:16]), 64'h14);

      // Asynchronous reset while channels sit in READ_WAIT
      #2;
      reset = 1'b1;
      #1;
      chk("t5_mrv", 64'(mrv), 64'h0);
      chk("t5_mra", 64'(mra), 64'h0);
      chk("t5_crr", 64'(crr), 64'h0);
      chk("t5_crd", crd, 64'h0);
      crv = '0;
      tick();
      reset = 1'b0;

      // Write: consumer 7 stores 0x11 at 0x0A (also the first request after reset)
      cwa[56 +: 8] = 8'h0A;
      cwd[56 +: 8] = 8'h11;
      cwv[7] = 1'b1;
      tick();
      chk("t4_mwv", 64'(mwv), 64'h1);
      chk("t4_mwa", 64'(mwa[7:0]), 64'h0A);
      chk("t4_mwd", 64'(mwd[7:0]), 64'h11);
      chk("t4_mrv", 64'(mrv), 64'h0);
      mwr[0] = 1'b1;
      tick();
      chk("t4_cwr", 64'(cwr), 64'h80);
      chk("t4_mwv_low", 64'(mwv), 64'h0);
      mwr = '0;
      tick();
      chk("t4_cwr_hold", 64'(cwr), 64'h80);
      cwv[7] = 1'b0;
      tick();
      chk("t4_cwr_drop", 64'(cwr), 64'h0);

      // Read over write from consumer 6
      cra[48 +: 8] = 8'h33;
      cwa[48 +: 8] = 8'h44;
      cwd[48 +: 8] = 8'h55;
      crv[6] = 1'b1;
      cwv[6] = 1'b1;
      tick();
      chk("rw_mrv", 64'(mrv), 64'h1);
      chk("rw_mwv", 64'(mwv), 64'h0);
      chk("rw_mra", 64'(mra[7:0]), 64'h33);
      mrr[0] = 1'b1;
      mrd[7:0] = 8'h66;
      tick();
      chk("rw_crr", 64'(crr), 64'h40);
      chk("rw_crd", 64'(crd[55:48]), 64'h66);
      chk("rw_cwr", 64'(cwr), 64'h0);
      mrr = '0;
      crv[6] = 1'b0;
      tick();
      chk("rw_crr_drop", 64'(crr), 64'h0);
      chk("rw_mwv_wait", 64'(mwv), 64'h0);
      tick();
      chk("rw_mwv", 64'(mwv), 64'h1);
      chk("rw_mwa", 64'(mwa[7:0]), 64'h44);
      chk("rw_mwd", 64'(mwd[7:0]), 64'h55);
      mwr[0] = 1'b1;
      tick();
      chk("rw_cwr", 64'(cwr), 64'h40);
      mwr = '0;
      cwv = '0;
      tick();
      chk("rw_cwr_drop", 64'(cwr), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
